mac_lane_scheduler: RTL and testbench
=====================================

# mac_lane_scheduler

Issues multiply-add operations (A·B + C) from several requesters onto the parallel multiply-add lanes and returns each result tagged with the requester that issued it. Requesters are arbitrated round-robin. Lanes are also allocated round-robin and tracked as busy for a fixed latency. The block sits between the requesting datapath blocks and the lane array; it replaces free-running clock division with explicit per-lane issue strobes.

## Interface
- REQUESTERS, 4, number of requester ports
- STREAMS, params::STREAMS (4), number of multiply-add lanes
- LANE_LATENCY, 4, cycles from a lane's issue strobe to its result being valid at lane_result
- INPUT_SIZE / OUTPUT_SIZE, from params, operand / result widths

Ports:
- clock  in  1  single clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  REQUESTERS  operation request per requester
- req_ready  out  REQUESTERS  one-hot grant; transfer when valid & ready
- req_a, req_b, req_c  in  REQUESTERS × INPUT_SIZE  operands per requester
- lane_issue  out  STREAMS  one-hot, one-cycle issue strobe
- lane_a, lane_b, lane_c  out  INPUT_SIZE  shared operand bus, valid while lane_issue ≠ 0
- lane_result  in  STREAMS × OUTPUT_SIZE  lane outputs
- res_valid  out  1  one-cycle result strobe
- res_id  out  $clog2(REQUESTERS)  requester index of the result
- res_data  out  OUTPUT_SIZE  result value
- busy  out  1  any operation in flight

## Operation
- Handshake:
  - At most one transfer per cycle.
  - req_ready is combinational from req_valid, the arbiter pointer and lane availability. It is 0 when no lane is free or reset_n = 0.
  - A requester must not make req_valid depend on req_ready.
  - Operands are held by the requester until the transfer.
- Requester arbitration:
  - Round-robin; priority starts at the index after the last granted requester.
  - Pointer resets to 0, so requester 0 has highest priority after reset.
- Lane allocation:
  - The granted op goes to the first free lane at or after the lane pointer.
  - The lane pointer advances past the chosen lane.
- Lane occupancy:
  - A lane handshaken in cycle T is ineligible in T+1 … T+LANE_LATENCY−1.
  - It is eligible again in T+LANE_LATENCY.
  - Its result is captured at the end of T+1+LANE_LATENCY. Re-issuing the lane in that capture cycle is legal.
- Tag store: per-lane register holding res_id, written at handshake.
- Completion:
  - Issues are serialized and latency is fixed, so at most one lane completes per cycle; no completion arbitration is needed.
  - res_data is lane_result unmodified; no width conversion.
- busy = 1 whenever any lane is occupied or its capture is pending.
- Reset mid-operation:
  - All in-flight ops are discarded and their results never reported.
  - Occupancy, tags and pointers are cleared.

## Timing
- Reset values: req_ready 0, lane_issue 0, lane_a/b/c 0, res_valid 0, res_id 0, res_data 0, busy 0.
- Handshake in cycle T:
  - lane_issue and lane_a/b/c registered, valid in T+1.
  - lane_result valid in T+1+LANE_LATENCY.
  - res_valid/res_id/res_data in T+2+LANE_LATENCY.
  - End-to-end latency is LANE_LATENCY+2.
- Throughput:
  - One op per cycle when STREAMS ≥ LANE_LATENCY.
  - Otherwise STREAMS ops per LANE_LATENCY cycles.
- res_valid is a single-cycle pulse with no backpressure. The consumer must accept every result.

## Structure
- The package params gains REQUESTERS, LANE_LATENCY and the typedefs req_id_t (logic [$clog2(REQUESTERS)-1:0]) and lane_idx_t (logic [$clog2(STREAMS)-1:0]).
- Sub-module rr_arbiter (parameter WIDTH; ports: request vector, enable, one-hot grant, pointer update on accept). It is instantiated twice: once for requesters, once for free lanes.
- Per-lane occupancy counters, tag registers and the result mux stay in mac_lane_scheduler.

## Test plan
- Single op:
  - Stimulus: requester 2 sends A=3, B=4, C=5; lane model returns A·B+C after 4 cycles.
  - Required: lane_issue=0001 in T+1; res_valid, res_id=2, res_data=17 in T+6.
- Full load:
  - Stimulus: all 4 requesters valid continuously; STREAMS=4, LANE_LATENCY=4.
  - Required: grants 0,1,2,3,0… every cycle; lane_issue rotates 0001,0010,0100,1000; results in issue order with matching ids.
- Lane starvation:
  - Stimulus: STREAMS=2, LANE_LATENCY=4, requester 0 always valid.
  - Required: req_ready pattern 1,1,0,0 repeating; lane 0 re-issued in the same cycle its previous result is captured.
- Fairness:
  - Stimulus: STREAMS=1, LANE_LATENCY=2; requesters 0 and 3 always valid.
  - Required: grants alternate 0,3,0,3, one every 2 cycles.
- Reset mid-flight:
  - Stimulus: 3 ops in flight, reset_n=0 for one cycle.
  - Required: no res_valid afterwards; busy=0; next request from requester 1 goes to lane 0.
- Idle:
  - Stimulus: no req_valid for 20 cycles.
  - Required: lane_issue, res_valid and busy stay 0; pointers unchanged.

Source files
------------

// File: rtl/mac_lane_scheduler_pkg.sv
// Shared sizing constants and index types for the multiply-add lane scheduler.
package mac_lane_scheduler_pkg;
    localparam int STREAMS      = 4;
    localparam int REQUESTERS   = 4;
    localparam int LANE_LATENCY = 4;
    localparam int INPUT_SIZE   = 16;
    localparam int OUTPUT_SIZE  = 32;

    typedef logic [$clog2(REQUESTERS)-1:0] req_id_t;
    typedef logic [$clog2(STREAMS)-1:0]    lane_idx_t;

    // Index width that stays legal for single-entry vectors.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mac_lane_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter; priority starts just after the last accepted grant.
module rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] request,
    input  logic             enable,
    input  logic             accept,
    output logic [WIDTH-1:0] grant
);
    import mac_lane_scheduler_pkg::*;

    localparam int PW = idx_width(WIDTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_next;

    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        grant    = '0;
        ptr_next = ptr_q;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < WIDTH; k++) begin
            idx = PW'((int'(ptr_q) + k) % WIDTH);
            if (enable && !found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = PW'((int'(idx) + 1) % WIDTH);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (accept && (|grant)) begin
            ptr_q <= ptr_next;
        end
    end
endmodule

// File: rtl/mac_lane_scheduler.sv
// Arbitrates requesters onto round-robin allocated multiply-add lanes and
// returns each lane result tagged with the requester that issued it.
module mac_lane_scheduler #(
    parameter int REQUESTERS   = mac_lane_scheduler_pkg::REQUESTERS,
    parameter int STREAMS      = mac_lane_scheduler_pkg::STREAMS,
    parameter int LANE_LATENCY = mac_lane_scheduler_pkg::LANE_LATENCY,
    parameter int INPUT_SIZE   = mac_lane_scheduler_pkg::INPUT_SIZE,
    parameter int OUTPUT_SIZE  = mac_lane_scheduler_pkg::OUTPUT_SIZE
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic [REQUESTERS-1:0]                    req_valid,
    output logic [REQUESTERS-1:0]                    req_ready,
    input  logic [REQUESTERS-1:0][INPUT_SIZE-1:0]    req_a,
    input  logic [REQUESTERS-1:0][INPUT_SIZE-1:0]    req_b,
    input  logic [REQUESTERS-1:0][INPUT_SIZE-1:0]    req_c,
    output logic [STREAMS-1:0]                       lane_issue,
    output logic [INPUT_SIZE-1:0]                    lane_a,
    output logic [INPUT_SIZE-1:0]                    lane_b,
    output logic [INPUT_SIZE-1:0]                    lane_c,
    input  logic [STREAMS-1:0][OUTPUT_SIZE-1:0]      lane_result,
    output logic                                     res_valid,
    output logic [mac_lane_scheduler_pkg::idx_width(REQUESTERS)-1:0] res_id,
    output logic [OUTPUT_SIZE-1:0]                   res_data,
    output logic                                     busy
);
    import mac_lane_scheduler_pkg::*;

    localparam int IW    = idx_width(REQUESTERS);
    localparam int LW    = idx_width(STREAMS);
    localparam int OCC_W = idx_width(LANE_LATENCY);

    logic [REQUESTERS-1:0]          req_grant;
    logic [STREAMS-1:0]             lane_free;
    logic [STREAMS-1:0]             lane_grant;
    logic                           handshake;
    logic [IW-1:0]                  grant_id;
    logic [LW-1:0]                  grant_lane;
    logic [INPUT_SIZE-1:0]          op_a;
    logic [INPUT_SIZE-1:0]          op_b;
    logic [INPUT_SIZE-1:0]          op_c;

    logic [STREAMS-1:0][OCC_W-1:0]  occ_cnt;
    logic [STREAMS-1:0][IW-1:0]     tag_q;
    logic [LANE_LATENCY:0]          pipe_valid;
    logic [LANE_LATENCY:0][LW-1:0]  pipe_lane;
    logic [IW-1:0]                  cap_id;

    rr_arbiter #(.WIDTH(REQUESTERS)) u_req_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .request (req_valid),
        .enable  (reset_n & (|lane_free)),
        .accept  (handshake),
        .grant   (req_grant)
    );

    rr_arbiter #(.WIDTH(STREAMS)) u_lane_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .request (lane_free),
        .enable  (reset_n & (|req_valid)),
        .accept  (handshake),
        .grant   (lane_grant)
    );

    assign req_ready = req_grant;
    assign handshake = |req_grant;

    always_comb begin
        for (int s = 0; s < STREAMS; s++) begin
            lane_free[s] = (occ_cnt[s] == '0);
        end
    end

    always_comb begin
        grant_id   = '0;
        grant_lane = '0;
        op_a       = '0;
        op_b       = '0;
        op_c       = '0;
        for (int r = 0; r < REQUESTERS; r++) begin
            if (req_grant[r]) begin
                grant_id = IW'(r);
                op_a     = req_a[r];
                op_b     = req_b[r];
                op_c     = req_c[r];
            end
        end
        for (int s = 0; s < STREAMS; s++) begin
            if (lane_grant[s]) begin
                grant_lane = LW'(s);
            end
        end
    end

    // A lane may be re-issued one cycle before its previous op is captured, so the
    // tag is copied out of the lane register the cycle before that overwrite lands.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            occ_cnt    <= '0;
            tag_q      <= '0;
            pipe_valid <= '0;
            pipe_lane  <= '0;
            cap_id     <= '0;
            lane_issue <= '0;
            lane_a     <= '0;
            lane_b     <= '0;
            lane_c     <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_data   <= '0;
        end else begin
            for (int s = 0; s < STREAMS; s++) begin
                if (handshake && lane_grant[s]) begin
                    occ_cnt[s] <= OCC_W'(LANE_LATENCY - 1);
                    tag_q[s]   <= grant_id;
                end else if (occ_cnt[s] != '0) begin
                    occ_cnt[s] <= occ_cnt[s] - OCC_W'(1);
                end
            end
            lane_issue <= handshake ? lane_grant : '0;
            if (handshake) begin
                lane_a <= op_a;
                lane_b <= op_b;
                lane_c <= op_c;
            end
            pipe_valid <= {pipe_valid[LANE_LATENCY-1:0], handshake};
            pipe_lane  <= {pipe_lane[LANE_LATENCY-1:0], grant_lane};
            cap_id     <= tag_q[pipe_lane[LANE_LATENCY-1]];
            res_valid  <= pipe_valid[LANE_LATENCY];
            if (pipe_valid[LANE_LATENCY]) begin
                res_id   <= cap_id;
                res_data <= lane_result[pipe_lane[LANE_LATENCY]];
            end
        end
    end

    assign busy = (|pipe_valid) | ~(&lane_free);
endmodule

// File: tb/tb_mac_lane_scheduler.sv
// Scoreboard bench for mac_lane_scheduler: three configurations (4x4, 2 lanes, 1 lane)
// each driven by directed vectors and backed by a fixed-latency lane model.
module tb_mac_lane_scheduler;
    import mac_lane_scheduler_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // d0: 4 lanes latency 4, d1: 2 lanes latency 4, d2: 1 lane latency 2
    logic [3:0]        rv0, rr0, rv1, rr1, rv2, rr2;
    logic [3:0][15:0]  ra0, rb0, rc0, ra1, rb1, rc1, ra2, rb2, rc2;
    logic [3:0]        li0;
    logic [1:0]        li1;
    logic [0:0]        li2;
    logic [15:0]       la0, lb0, lc0, la1, lb1, lc1, la2, lb2, lc2;
    logic [3:0][31:0]  lr0;
    logic [1:0][31:0]  lr1;
    logic [0:0][31:0]  lr2;
    logic              v0, v1, v2, busy0, busy1, busy2;
    req_id_t           id0, id1, id2;
    logic [31:0]       d0, d1, d2;

    mac_lane_scheduler u_dut0 (
        .clock(clock), .reset_n(reset_n), .req_valid(rv0), .req_ready(rr0),
        .req_a(ra0), .req_b(rb0), .req_c(rc0), .lane_issue(li0),
        .lane_a(la0), .lane_b(lb0), .lane_c(lc0), .lane_result(lr0),
        .res_valid(v0), .res_id(id0), .res_data(d0), .busy(busy0)
    );

    mac_lane_scheduler #(.STREAMS(2), .LANE_LATENCY(4)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .req_valid(rv1), .req_ready(rr1),
        .req_a(ra1), .req_b(rb1), .req_c(rc1), .lane_issue(li1),
        .lane_a(la1), .lane_b(lb1), .lane_c(lc1), .lane_result(lr1),
        .res_valid(v1), .res_id(id1), .res_data(d1), .busy(busy1)
    );

    mac_lane_scheduler #(.STREAMS(1), .LANE_LATENCY(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .req_valid(rv2), .req_ready(rr2),
        .req_a(ra2), .req_b(rb2), .req_c(rc2), .lane_issue(li2),
        .lane_a(la2), .lane_b(lb2), .lane_c(lc2), .lane_result(lr2),
        .res_valid(v2), .res_id(id2), .res_data(d2), .busy(busy2)
    );

    // Lane model: result is valid only in the cycle exactly LATENCY after the issue strobe.
    typedef struct packed {
        logic [3:0]  iss;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } hist_t;

    hist_t h0 [4] = '{default: '0};
    hist_t h1 [4] = '{default: '0};
    hist_t h2 [2] = '{default: '0};

    always @(posedge clock) begin
        h0[0] <= {li0, la0, lb0, lc0};
        h1[0] <= {2'b00, li1, la1, lb1, lc1};
        h2[0] <= {3'b000, li2, la2, lb2, lc2};
        for (int i = 1; i < 4; i++) begin
            h0[i] <= h0[i-1];
            h1[i] <= h1[i-1];
        end
        h2[1] <= h2[0];
    end

    function automatic logic [31:0] lane_out(input hist_t h, input logic [1:0] s);
        return h.iss[s] ? (32'(h.a) * 32'(h.b) + 32'(h.c)) : 32'hDEAD_BEEF;
    endfunction

    always_comb begin
        for (int s = 0; s < 4; s++) lr0[s] = lane_out(h0[3], 2'(s));
        for (int s = 0; s < 2; s++) lr1[s] = lane_out(h1[3], 2'(s));
        lr2[0] = lane_out(h2[1], 2'd0);
    end

    // Scoreboard
    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];
    sb_t q2[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int d, input int id, input logic [31:0] data, input int due);
        sb_t e;
        e.id = id; e.data = data; e.due = due;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic take(input int d, input logic [31:0] gid, input logic [31:0] gdata);
        sb_t  e;
        logic have;
        have = 1'b0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            total++;
            bad++;
            $display("FAIL unexpected_result dut%0d: got id=%0d data=%0h expected no result (cycle %0d)",
                     d, gid, gdata, cyc);
        end else begin
            check($sformatf("res_id dut%0d", d), 64'(gid), 64'(e.id));
            check($sformatf("res_data dut%0d", d), 64'(gdata), 64'(e.data));
            check($sformatf("res_cycle dut%0d", d), 64'(cyc), 64'(e.due));
        end
    endtask

    always @(negedge clock) begin
        if (v0 === 1'b1) take(0, 32'(id0), d0);
        if (v1 === 1'b1) take(1, 32'(id1), d1);
        if (v2 === 1'b1) take(2, 32'(id2), d2);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && i < 30) begin
            @(negedge clock);
            i++;
        end
        check({name, " results_outstanding"}, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        q0.delete(); q1.delete(); q2.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int fl_res [4] = '{7, 37, 122, 20300};
    int t;

    initial begin
        reset_n = 1'b0;
        rv0 = '0; rv1 = '0; rv2 = '0;
        ra0 = '0; rb0 = '0; rc0 = '0;
        ra1 = '0; rb1 = '0; rc1 = '0;
        ra2 = '0; rb2 = '0; rc2 = '0;
        ra0[0] = 2;   rb0[0] = 3;   rc0[0] = 1;
        ra0[1] = 5;   rb0[1] = 6;   rc0[1] = 7;
        ra0[2] = 10;  rb0[2] = 11;  rc0[2] = 12;
        ra0[3] = 100; rb0[3] = 200; rc0[3] = 300;
        rv0 = 4'hF;

        // Reset state, with requests present to confirm ready stays low
        repeat (3) step();
        @(negedge clock);
        check("reset req_ready", 64'(rr0), 64'd0);
        check("reset lane_issue", 64'(li0), 64'd0);
        check("reset lane_a", 64'(la0), 64'd0);
        check("reset res_valid", 64'(v0), 64'd0);
        check("reset res_id", 64'(id0), 64'd0);
        check("reset res_data", 64'(d0), 64'd0);
        check("reset busy", 64'(busy0), 64'd0);

        // Full load: grants and lanes rotate every cycle
        step();
        reset_n = 1'b1;
        t = cyc;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("full grant", 64'(rr0), 64'(1 << (k % 4)));
            check("full issue", 64'(li0), (k == 0) ? 64'd0 : 64'(1 << ((k - 1) % 4)));
            push(0, k % 4, 32'(fl_res[k % 4]), t + k + 6);
            step();
        end
        rv0 = '0;
        @(negedge clock);
        check("full last issue", 64'(li0), 64'b1000);
        drain("full");
        check("full idle busy", 64'(busy0), 64'd0);

        // Single op from requester 2 lands on lane 0
        step();
        rv0 = 4'b0100;
        ra0[2] = 3; rb0[2] = 4; rc0[2] = 5;
        t = cyc;
        @(negedge clock);
        check("single grant", 64'(rr0), 64'b0100);
        push(0, 2, 32'd17, t + 6);
        step();
        rv0 = '0;
        @(negedge clock);
        check("single issue", 64'(li0), 64'b0001);
        check("single lane_a", 64'(la0), 64'd3);
        check("single lane_b", 64'(lb0), 64'd4);
        check("single lane_c", 64'(lc0), 64'd5);
        check("single busy", 64'(busy0), 64'd1);
        drain("single");

        // Reset with three ops in flight: none may be reported
        step();
        rv0 = 4'b0111;
        @(negedge clock);
        check("flight grant0", 64'(rr0), 64'b0001);
        step();
        @(negedge clock);
        check("flight grant1", 64'(rr0), 64'b0010);
        step();
        @(negedge clock);
        check("flight grant2", 64'(rr0), 64'b0100);
        step();
        reset_n = 1'b0;
        rv0 = 4'b0010;
        @(negedge clock);
        check("flight ready under reset", 64'(rr0), 64'd0);
        step();
        reset_n = 1'b1;
        t = cyc;
        @(negedge clock);
        check("post reset busy", 64'(busy0), 64'd0);
        check("post reset grant", 64'(rr0), 64'b0010);
        push(0, 1, 32'd37, t + 6);
        step();
        rv0 = '0;
        @(negedge clock);
        check("post reset lane", 64'(li0), 64'b0001);
        drain("flight");

        // Idle: nothing moves and pointers hold
        for (int k = 0; k < 20; k++) begin
            step();
            @(negedge clock);
            check("idle lane_issue", 64'(li0), 64'd0);
            check("idle res_valid", 64'(v0), 64'd0);
            check("idle busy", 64'(busy0), 64'd0);
        end
        step();
        rv0 = 4'hF;
        t = cyc;
        @(negedge clock);
        check("idle ptr grant", 64'(rr0), 64'b0100);
        push(0, 2, 32'd17, t + 6);
        step();
        rv0 = '0;
        @(negedge clock);
        check("idle ptr lane", 64'(li0), 64'b0010);
        drain("idle");

        // Lane starvation with two lanes
        step();
        rv1 = 4'b0001;
        ra1[0] = 7; rb1[0] = 8; rc1[0] = 9;
        t = cyc;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            check("starve ready", 64'(rr1), ((k % 4) < 2) ? 64'd1 : 64'd0);
            if ((k % 4) < 2) push(1, 0, 32'd65, t + k + 6);
            if (k >= 1 && ((k - 1) % 4) < 2)
                check("starve issue", 64'(li1), (((k - 1) % 4) == 0) ? 64'b01 : 64'b10);
            else
                check("starve issue", 64'(li1), 64'd0);
            step();
        end
        rv1 = '0;
        drain("starve");

        // Fairness on a single lane
        step();
        rv2 = 4'b1001;
        ra2[0] = 1; rb2[0] = 2; rc2[0] = 3;
        ra2[3] = 4; rb2[3] = 5; rc2[3] = 6;
        t = cyc;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if ((k % 2) == 1) begin
                check("fair ready", 64'(rr2), 64'd0);
            end else if (((k / 2) % 2) == 0) begin
                check("fair ready", 64'(rr2), 64'b0001);
                push(2, 0, 32'd5, t + k + 4);
            end else begin
                check("fair ready", 64'(rr2), 64'b1000);
                push(2, 3, 32'd26, t + k + 4);
            end
            step();
        end
        rv2 = '0;
        drain("fair");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
